// File: rtl/fnd_pkg.sv
// Shared definitions for the shared 7-segment display arbiter: state encoding,
// requester count, blank pattern and requester-selection helpers.
package fnd_pkg;

    localparam int         NUM_REQ   = 3;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN      = 2'd1,
        HANDOVER = 2'd2
    } arb_state_e;

    function automatic logic [1:0] lowest_req(input logic [NUM_REQ-1:0] r);
        lowest_req = r[0] ? 2'd0 : r[1] ? 2'd1 : 2'd2;
    endfunction

    // First active requester after 'last', wrapping 0->1->2->0; 'last' itself is checked last.
    function automatic logic [1:0] rr_next(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
        case (last)
            2'd0:    rr_next = r[1] ? 2'd1 : r[2] ? 2'd2 : 2'd0;
            2'd1:    rr_next = r[2] ? 2'd2 : r[0] ? 2'd0 : 2'd1;
            default: rr_next = r[0] ? 2'd0 : r[1] ? 2'd1 : 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/decoder_7seg.sv
// Hex to 7-segment decoder, active-high segments {dp,g,f,e,d,c,b,a}; dp is never lit.
module decoder_7seg (
    input  logic [3:0] hex_value,
    output logic [7:0] seg_7
);

    always_comb begin
        seg_7 = 8'h00;
        case (hex_value)
            4'h0: seg_7 = 8'h3F;
            4'h1: seg_7 = 8'h06;
            4'h2: seg_7 = 8'h5B;
            4'h3: seg_7 = 8'h4F;
            4'h4: seg_7 = 8'h66;
            4'h5: seg_7 = 8'h6D;
            4'h6: seg_7 = 8'h7D;
            4'h7: seg_7 = 8'h07;
            4'h8: seg_7 = 8'h7F;
            4'h9: seg_7 = 8'h6F;
            4'hA: seg_7 = 8'h77;
            4'hB: seg_7 = 8'h7C;
            4'hC: seg_7 = 8'h39;
            4'hD: seg_7 = 8'h5E;
            4'hE: seg_7 = 8'h79;
            default: seg_7 = 8'h71;
        endcase
    end

endmodule

// File: rtl/fnd_scan.sv
// Digit scanner: free-running slot counter, active-low com ring and registered
// active-low segments that always belong to the com driven in the same cycle.
module fnd_scan
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] value,
    input  logic        blank,
    output logic [3:0]  com,
    output logic [7:0]  seg_7
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    nib;
    logic [7:0]    dec;
    logic          wrap;

    decoder_7seg u_dec (
        .hex_value (nib),
        .seg_7     (dec)
    );

    // Nibble and blank follow the next com so seg_7 and com update on the same edge.
    always_comb begin
        wrap  = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        com_d = wrap ? {com_q[2:0], com_q[3]} : com_q;
        case (com_d)
            4'b1110: nib = value[3:0];
            4'b1101: nib = value[7:4];
            4'b1011: nib = value[11:8];
            default: nib = value[15:12];
        endcase
        seg_d = blank ? SEG_BLANK : {1'b1, ~dec[6:0]};
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt_q <= '0;
            com_q <= 4'b1110;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            com_q <= com_d;
            seg_q <= seg_d;
        end
    end

    assign com   = com_q;
    assign seg_7 = seg_q;

endmodule

// File: rtl/fnd_share_arbiter.sv
// Shares one 4-digit 7-segment display between three requesters with a minimum
// hold time, a one-cycle blank handover and round-robin preemption.
module fnd_share_arbiter
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int HOLD_CYC = 100000000
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [15:0]         value0,
    input  logic [15:0]         value1,
    input  logic [15:0]         value2,
    output logic [NUM_REQ-1:0]  grant,
    output logic                busy,
    output logic [3:0]          com,
    output logic [7:0]          seg_7
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    arb_state_e           state_q, state_d;
    logic [1:0]           owner_q, owner_d;   // current owner, or last owner when not in OWN
    logic [HW-1:0]        hold_q, hold_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   others;
    logic [15:0]          value_sel;
    logic                 blank;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        others  = req & ~grant_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    owner_d = lowest_req(req);
                    hold_d  = '0;
                end
            end
            OWN: begin
                if (!(|(req & grant_q))) begin
                    state_d = (|others) ? HANDOVER : IDLE;
                end else if (hold_q == HW'(HOLD_CYC) && (|others)) begin
                    state_d = HANDOVER;
                end else if (hold_q != HW'(HOLD_CYC)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            HANDOVER: begin
                if (|req) begin
                    state_d = OWN;
                    owner_d = rr_next(req, owner_q);
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == OWN) ? (NUM_REQ'(1) << owner_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    // Scanner is fed from next-state so segments line up with the registered grant.
    always_comb begin
        case (owner_d)
            2'd0:    value_sel = value0;
            2'd1:    value_sel = value1;
            default: value_sel = value2;
        endcase
        blank = (state_d != OWN);
    end

    fnd_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk     (clk),
        .reset_p (reset_p),
        .value   (value_sel),
        .blank   (blank),
        .com     (com),
        .seg_7   (seg_7)
    );

    assign grant = grant_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_fnd_share_arbiter.sv
// Scoreboard bench for fnd_share_arbiter: directed scenarios then random traffic,
// expectations from a requester-level behavioural model.
module tb_fnd_share_arbiter;

    localparam int SCAN = 4;
    localparam int HOLD = 20;

    typedef struct {
        logic [2:0] grant;
        logic       busy;
        logic [3:0] com;
        logic [7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [15:0] value0 = '0, value1 = '0, value2 = '0;
    logic [2:0]  grant;
    logic        busy;
    logic [3:0]  com;
    logic [7:0]  seg_7;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t expq[$];
    logic [15:0] nv [3];
    logic [6:0]  pat [16];

    // behavioural model state
    int m_own;      // -1 = nobody
    bit m_ho;
    int m_hold, m_last, m_cnt, m_dig;

    fnd_share_arbiter #(.SCAN_DIV(SCAN), .HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .req     (req),
        .value0  (value0),
        .value1  (value1),
        .value2  (value2),
        .grant   (grant),
        .busy    (busy),
        .com     (com),
        .seg_7   (seg_7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    task automatic model_step(input logic rst, input logic [2:0] r);
        int others;
        if (rst) begin
            m_own = -1; m_ho = 0; m_hold = 0; m_last = 0; m_cnt = 0; m_dig = 0;
            return;
        end
        if (m_cnt == SCAN - 1) begin
            m_cnt = 0;
            m_dig = (m_dig + 1) % 4;
        end else begin
            m_cnt++;
        end
        if (m_ho) begin
            m_ho = 0;
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (r[idx]) begin
                    m_own = idx; m_last = idx; m_hold = 0;
                    break;
                end
            end
        end else if (m_own < 0) begin
            for (int i = 0; i < 3; i++) begin
                if (r[i]) begin
                    m_own = i; m_last = i; m_hold = 0;
                    break;
                end
            end
        end else begin
            others = int'(r) & ~(1 << m_own);
            if (!r[m_own]) begin
                m_own = -1;
                m_ho  = (others != 0);
            end else if (m_hold == HOLD && others != 0) begin
                m_own = -1;
                m_ho  = 1;
            end else if (m_hold < HOLD) begin
                m_hold++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [15:0] v;
        logic [3:0]  nib;
        e.grant = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        e.busy  = (m_own >= 0);
        e.com   = ~(4'b0001 << m_dig);
        if (m_own >= 0) begin
            v   = nv[m_own];
            nib = 4'(v >> (4 * m_dig));
            e.seg = {1'b1, ~pat[nib]};
        end else begin
            e.seg = 8'hFF;
        end
        return e;
    endfunction

    task automatic cyc(input logic rst, input logic [2:0] r);
        @(negedge clk);
        reset_p = rst;
        req     = r;
        value0  = nv[0];
        value1  = nv[1];
        value2  = nv[2];
        model_step(rst, r);
        expq.push_back(model_out());
    endtask

    task automatic run(input logic rst, input logic [2:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(rst, r);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("grant", {5'd0, grant}, {5'd0, e.grant});
                chk("busy", {7'd0, busy}, {7'd0, e.busy});
                chk("com", {4'd0, com}, {4'd0, e.com});
                chk("seg_7", seg_7, e.seg);
                chk("onehot", {7'd0, $onehot0(grant)}, 8'd1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0] r;
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        nv[0] = 16'h1234; nv[1] = 16'hABCD; nv[2] = 16'h5E0F;
        model_step(1'b1, 3'b000);

        run(1, 3'b000, 3);          // reset held
        run(0, 3'b000, 6);          // idle scanning
        run(0, 3'b011, 8);          // simultaneous -> owner 0
        run(0, 3'b000, 2);
        run(0, 3'b001, 6);          // owner 0, hold counting
        run(0, 3'b011, 26);         // req1 rises mid-hold -> handover -> 1
        run(0, 3'b000, 6);          // owner 1 releases, blank scan
        run(0, 3'b100, 24);         // owner 2, hold saturates
        run(0, 3'b101, 5);          // round-robin wrap to 0
        run(0, 3'b000, 3);
        run(0, 3'b100, 5);
        run(1, 3'b100, 1);          // mid-OWN reset pulse
        run(0, 3'b100, 5);
        run(0, 3'b110, 22);         // handover 2 -> 1? (no: owner 2 keeps until hold)
        run(0, 3'b010, 3);
        run(0, 3'b101, 2);          // owner drops with others set
        run(0, 3'b000, 1);
        run(0, 3'b000, 4);

        r = 3'b000;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) nv[$urandom_range(0, 2)] = 16'($urandom);
            cyc(($urandom_range(0, 199) == 0), r);
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", 8'(expq.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
